// File: rtl/priority_decoder.sv
// ============================================================================
//  Module      : priority_decoder
//  Description : 3-bit code stream -> one-hot strobe, 2-entry input FIFO,
//                each word held for HOLD cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_decoder #(
   parameter int HOLD  = 4,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] code,
   input  logic       none,
   input  logic       code_valid,
   output logic       code_ready,
   output logic [7:0] out,
   output logic       out_valid,
   output logic       busy
);

   localparam logic [7:0] c_hold_reload = 8'(HOLD - 1);
   localparam logic [1:0] c_full_count  = 2'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] out_q, out_d;
   logic       out_valid_q, out_valid_d;

   // FIFO entry layout: {none, code}
   logic [3:0] fifo_q [2];
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] count_q, count_d;

   logic       w_push;
   logic       w_pop;
   logic [3:0] w_head;
   logic [7:0] w_head_word;

   // No pass-through when full: ready depends on the stored count only.
   assign code_ready  = ~rst & (count_q != c_full_count);
   assign w_push      = code_valid & code_ready;
   assign w_head      = fifo_q[rd_ptr_q];
   assign w_head_word = w_head[3] ? 8'h00 : (8'h01 << w_head[2:0]);

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      w_pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != 2'd0) begin
               w_pop       = 1'b1;
               out_d       = w_head_word;
               out_valid_d = 1'b1;
               hold_cnt_d  = c_hold_reload;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q != 8'd0) begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end else if (count_q != 2'd0) begin
               w_pop       = 1'b1;
               out_d       = w_head_word;
               out_valid_d = 1'b1;
               hold_cnt_d  = c_hold_reload;
            end else begin
               out_d       = 8'h00;
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_d       = 8'h00;
            out_valid_d = 1'b0;
            hold_cnt_d  = 8'd0;
         end
      endcase
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_cnt_q  <= 8'd0;
         out_q       <= 8'h00;
         out_valid_q <= 1'b0;
         fifo_q[0]   <= 4'h0;
         fifo_q[1]   <= 4'h0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         count_q     <= count_d;
         if (w_push) begin
            fifo_q[wr_ptr_q] <= {none, code};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == S_HOLD) | (count_q != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_priority_decoder.sv
// ============================================================================
//  Module      : tb_priority_decoder
//  Description : Directed and model-checked bench for priority_decoder,
//                one instance per HOLD value {4,1,2,3,255}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_decoder;

   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] tb_code      [N];
   logic       tb_none      [N];
   logic       tb_valid     [N];
   logic       tb_ready     [N];
   logic [7:0] tb_out       [N];
   logic       tb_out_valid [N];
   logic       tb_busy      [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      priority_decoder #(
         .HOLD ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 3 : 255),
         .DEPTH(2)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .code      (tb_code[g]),
         .none      (tb_none[g]),
         .code_valid(tb_valid[g]),
         .code_ready(tb_ready[g]),
         .out       (tb_out[g]),
         .out_valid (tb_out_valid[g]),
         .busy      (tb_busy[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic v, input logic n, input logic [2:0] c);
      tb_valid[i] = v;
      tb_none[i]  = n;
      tb_code[i]  = c;
   endtask

   // {out, out_valid}
   task automatic chk_out(input string tag, input int i, input logic [7:0] o, input logic ov);
      chk(tag, {23'd0, tb_out[i], tb_out_valid[i]}, {23'd0, o, ov});
   endtask

   // Reference: pending queue plus the entry currently shown and its cycles left.
   task automatic soak(input int i, input int hold, input int cycles, input int pct);
      logic [3:0] q[$];
      logic [3:0] cur;
      logic [7:0] one;
      logic [7:0] eo;
      logic       cur_v;
      logic       v, n, push;
      logic [2:0] c;
      int         left;
      cur   = 4'h0;
      cur_v = 1'b0;
      left  = 0;
      one   = 8'h01;
      for (int t = 0; t < cycles; t++) begin
         eo = (cur_v && !cur[3]) ? (one << cur[2:0]) : 8'h00;
         chk($sformatf("soak_hold%0d_cyc%0d", hold, t),
             {21'd0, tb_out[i], tb_out_valid[i], tb_ready[i], tb_busy[i]},
             {21'd0, eo, cur_v, (q.size() < 2), (cur_v || (q.size() != 0))});
         v = ($urandom_range(0, 99) < pct);
         n = ($urandom_range(0, 7) == 0);
         c = 3'($urandom_range(0, 7));
         drive(i, v, n, c);
         push = v && (q.size() < 2);
         step();
         if (cur_v && left > 1) begin
            left--;
         end else if (q.size() != 0) begin
            cur   = q.pop_front();
            cur_v = 1'b1;
            left  = hold;
         end else begin
            cur_v = 1'b0;
         end
         if (push) q.push_back({n, c});
      end
      drive(i, 1'b0, 1'b0, 3'd0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 3'd0);
      #3;
      chk_out("reset_out", 0, 8'h00, 1'b0);
      chk("reset_ready", {31'd0, tb_ready[0]}, 32'd0);
      chk("reset_busy",  {31'd0, tb_busy[0]},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("ready_after_reset", {31'd0, tb_ready[0]}, 32'd1);

      // Single code 3, HOLD=4
      drive(0, 1'b1, 1'b0, 3'd3);
      step();
      drive(0, 1'b0, 1'b0, 3'd0);
      chk("t1_latency", {22'd0, tb_out[0], tb_out_valid[0], tb_busy[0]}, {22'd0, 8'h00, 1'b0, 1'b1});
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out($sformatf("t1_hold%0d", k), 0, 8'h08, 1'b1);
      end
      step();
      chk("t1_end", {22'd0, tb_out[0], tb_out_valid[0], tb_busy[0]}, 32'd0);

      // Codes 0..7 streamed, HOLD=1
      for (int k = 0; k < 8; k++) begin
         drive(1, 1'b1, 1'b0, k[2:0]);
         chk($sformatf("t2_ready%0d", k), {31'd0, tb_ready[1]}, 32'd1);
         step();
         if (k >= 1) chk_out($sformatf("t2_out%0d", k - 1), 1, 8'h01 << (k - 1), 1'b1);
      end
      drive(1, 1'b0, 1'b0, 3'd0);
      step();
      chk_out("t2_out7", 1, 8'h80, 1'b1);
      step();
      chk_out("t2_end", 1, 8'h00, 1'b0);

      // Backpressure 5,6,7, HOLD=4
      drive(0, 1'b1, 1'b0, 3'd5);
      chk("t3_ready5", {31'd0, tb_ready[0]}, 32'd1);
      step();
      chk_out("t3_e1", 0, 8'h00, 1'b0);
      drive(0, 1'b1, 1'b0, 3'd6);
      chk("t3_ready6", {31'd0, tb_ready[0]}, 32'd1);
      step();
      chk_out("t3_e2", 0, 8'h20, 1'b1);
      drive(0, 1'b1, 1'b0, 3'd7);
      chk("t3_ready7", {31'd0, tb_ready[0]}, 32'd1);
      step();
      drive(0, 1'b0, 1'b0, 3'd0);
      chk("t3_full_e3", {31'd0, tb_ready[0]}, 32'd0);
      chk_out("t3_e3", 0, 8'h20, 1'b1);
      step();
      chk("t3_full_e4", {31'd0, tb_ready[0]}, 32'd0);
      chk_out("t3_e4", 0, 8'h20, 1'b1);
      step();
      chk("t3_full_e5", {31'd0, tb_ready[0]}, 32'd0);
      chk_out("t3_e5", 0, 8'h20, 1'b1);
      step();
      chk("t3_ready_e6", {31'd0, tb_ready[0]}, 32'd1);
      chk_out("t3_e6", 0, 8'h40, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out($sformatf("t3_hold40_%0d", k), 0, 8'h40, 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out($sformatf("t3_hold80_%0d", k), 0, 8'h80, 1'b1);
      end
      step();
      chk("t3_end", {22'd0, tb_out[0], tb_out_valid[0], tb_busy[0]}, 32'd0);

      // None entry then code 2, HOLD=2
      drive(2, 1'b1, 1'b1, 3'd6);
      step();
      drive(2, 1'b1, 1'b0, 3'd2);
      step();
      drive(2, 1'b0, 1'b0, 3'd0);
      chk_out("t4_none0", 2, 8'h00, 1'b1);
      step();
      chk_out("t4_none1", 2, 8'h00, 1'b1);
      step();
      chk_out("t4_code0", 2, 8'h04, 1'b1);
      step();
      chk_out("t4_code1", 2, 8'h04, 1'b1);
      step();
      chk_out("t4_end", 2, 8'h00, 1'b0);

      // Reset while holding 8'h10 with a full FIFO
      drive(0, 1'b1, 1'b0, 3'd4);
      step();
      drive(0, 1'b1, 1'b0, 3'd1);
      step();
      chk_out("t5_hold", 0, 8'h10, 1'b1);
      drive(0, 1'b1, 1'b0, 3'd2);
      step();
      drive(0, 1'b0, 1'b0, 3'd0);
      chk("t5_full", {31'd0, tb_ready[0]}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("t5_rst_out", 0, 8'h00, 1'b0);
      chk("t5_rst_ready", {31'd0, tb_ready[0]}, 32'd0);
      chk("t5_rst_busy",  {31'd0, tb_busy[0]},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("t5_ready_after", {31'd0, tb_ready[0]}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         chk("t5_empty", {22'd0, tb_out[0], tb_out_valid[0], tb_busy[0]}, 32'd0);
         step();
      end

      // Model-checked random traffic
      soak(1, 1,   400,  60);
      soak(3, 3,   600,  50);
      soak(4, 255, 1600, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
